// File: rtl/jam_pkg.sv
// Shared types and helpers for the jam_param permutation search engine.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CMP,
    NEXT,
    DONE
  } jam_state_e;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // ceil(log2(v)), but never less than 1 so a single-bit field is always legal
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation of 0..N-1.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] perm_in,
  output logic [N*IDX_W-1:0] perm_out,
  output logic               is_last
);

  typedef logic [N-1:0][IDX_W-1:0] perm_t;

  perm_t             cur;
  perm_t             swapped;
  perm_t             nxt;
  int                pivot;
  int                succ;
  logic              found;
  logic [IDX_W-1:0]  piv_val;
  logic [IDX_W-1:0]  succ_val;

  always_comb begin
    cur      = perm_in;
    found    = 1'b0;
    pivot    = 0;
    piv_val  = '0;
    succ     = 0;
    succ_val = '0;
    swapped  = cur;
    nxt      = cur;

    for (int i = 0; i < N - 1; i++) begin
      if (cur[i] < cur[i+1]) begin
        found = 1'b1;
        pivot = i;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (i == pivot) piv_val = cur[i];
    end

    // The suffix after the pivot is descending, so the last larger entry is the smallest larger one
    for (int j = 0; j < N; j++) begin
      if (j > pivot && cur[j] > piv_val) begin
        succ     = j;
        succ_val = cur[j];
      end
    end

    for (int i = 0; i < N; i++) begin
      if (i == pivot)      swapped[i] = succ_val;
      else if (i == succ)  swapped[i] = piv_val;
      else                 swapped[i] = cur[i];
    end

    nxt = swapped;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < N; m++) begin
        if (k > pivot && m == N + pivot - k) nxt[k] = swapped[m];
      end
    end

    is_last  = ~found;
    perm_out = found ? nxt : cur;
  end

endmodule

// File: rtl/jam_param.sv
// Brute-force job assignment: walks all N! permutations against an external
// cost table and reports the optimal total, its multiplicity and the first optimum.
module jam_param
  import jam_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int COST_W = 7,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = clog2_min1(N),
  localparam int SUM_W  = COST_W + clog2_min1(N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic [IDX_W-1:0]   W,
  output logic [IDX_W-1:0]   J,
  input  logic [COST_W-1:0]  Cost,
  output logic [SUM_W-1:0]   MinCost,
  output logic [CNT_W-1:0]   MatchCount,
  output logic [N*IDX_W-1:0] BestPerm,
  output logic               Valid
);

  typedef logic [N-1:0][IDX_W-1:0] perm_t;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

  function automatic perm_t identity_perm();
    perm_t p;
    for (int k = 0; k < N; k++) p[k] = IDX_W'(k);
    return p;
  endfunction

  jam_state_e        state_q, state_d;
  logic              mode_q, mode_d;
  logic              first_q, first_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  best_q, best_d;
  logic [CNT_W-1:0]  count_q, count_d;
  perm_t             perm_q, perm_d;
  perm_t             best_perm_q, best_perm_d;
  logic [SUM_W-1:0]  min_cost_q, min_cost_d;
  logic [CNT_W-1:0]  match_q, match_d;
  perm_t             res_perm_q, res_perm_d;

  perm_t             perm_succ;
  logic              is_last;
  logic              better;
  logic [IDX_W-1:0]  j_sel;

  jam_next_perm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_next (
    .perm_in  (perm_q),
    .perm_out (perm_succ),
    .is_last  (is_last)
  );

  always_comb begin
    better = (mode_q == MODE_MAX) ? (sum_q > best_q) : (sum_q < best_q);
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    first_d     = first_q;
    k_d         = k_q;
    sum_d       = sum_q;
    best_d      = best_q;
    count_d     = count_q;
    perm_d      = perm_q;
    best_perm_d = best_perm_q;
    min_cost_d  = min_cost_q;
    match_d     = match_q;
    res_perm_d  = res_perm_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          first_d     = 1'b1;
          k_d         = '0;
          sum_d       = '0;
          best_d      = '0;
          count_d     = '0;
          best_perm_d = '0;
          perm_d      = identity_perm();
          state_d     = READ;
        end
      end

      READ: begin
        sum_d = sum_q + SUM_W'(Cost);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = CMP;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end

      CMP: begin
        if (first_q || better) begin
          best_d      = sum_q;
          count_d     = CNT_W'(1);
          best_perm_d = perm_q;
        end else if (sum_q == best_q) begin
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
        end
        first_d = 1'b0;
        sum_d   = '0;
        // Results land on the edge into DONE so they are stable while Valid is high
        if (is_last) begin
          min_cost_d = best_d;
          match_d    = count_d;
          res_perm_d = best_perm_d;
          state_d    = DONE;
        end else begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        perm_d  = perm_succ;
        state_d = READ;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mode_q      <= MODE_MIN;
      first_q     <= 1'b0;
      k_q         <= '0;
      sum_q       <= '0;
      best_q      <= '0;
      count_q     <= '0;
      perm_q      <= identity_perm();
      best_perm_q <= '0;
      min_cost_q  <= '0;
      match_q     <= '0;
      res_perm_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      first_q     <= first_d;
      k_q         <= k_d;
      sum_q       <= sum_d;
      best_q      <= best_d;
      count_q     <= count_d;
      perm_q      <= perm_d;
      best_perm_q <= best_perm_d;
      min_cost_q  <= min_cost_d;
      match_q     <= match_d;
      res_perm_q  <= res_perm_d;
    end
  end

  always_comb begin
    j_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (k_q == IDX_W'(k)) j_sel = perm_q[k];
    end
  end

  assign W          = (state_q == READ) ? k_q : '0;
  assign J          = (state_q == READ) ? j_sel : '0;
  assign busy       = (state_q != IDLE);
  assign Valid      = (state_q == DONE);
  assign MinCost    = min_cost_q;
  assign MatchCount = match_q;
  assign BestPerm   = res_perm_q;

endmodule

// File: tb/tb_jam_param.sv
// Self-checking bench for jam_param: N=3 and N=4 instances against a
// brute-force reference that enumerates base-N tuples and keeps the permutations.
module tb_jam_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start3, mode3, start4, mode4;
  logic       busy3, busy4, valid3, valid4;
  logic [1:0] w3, j3, w4, j4;
  logic [6:0] cost3, cost4;
  logic [8:0] minc3, minc4;
  logic [15:0] mc3, mc4;
  logic [5:0] bp3;
  logic [7:0] bp4;

  logic [6:0] tab3 [4][4];
  logic [6:0] tab4 [4][4];

  int total = 0;
  int bad   = 0;

  int         exp_cost;
  int         exp_cnt;
  logic [7:0] exp_perm;
  int         qw[$];
  int         qj[$];
  int         prev_cost [5];

  always #5 CLK = ~CLK;

  assign cost3 = tab3[w3][j3];
  assign cost4 = tab4[w4][j4];

  jam_param #(.N(3)) dut3 (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start3),
    .mode       (mode3),
    .busy       (busy3),
    .W          (w3),
    .J          (j3),
    .Cost       (cost3),
    .MinCost    (minc3),
    .MatchCount (mc3),
    .BestPerm   (bp3),
    .Valid      (valid3)
  );

  jam_param #(.N(4)) dut4 (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start4),
    .mode       (mode4),
    .busy       (busy4),
    .W          (w4),
    .J          (j4),
    .Cost       (cost4),
    .MinCost    (minc4),
    .MatchCount (mc4),
    .BestPerm   (bp4),
    .Valid      (valid4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setStart(input int n, input logic s, input logic m);
    if (n == 3) begin
      start3 = s;
      mode3  = m;
    end else begin
      start4 = s;
      mode4  = m;
    end
  endtask

  task automatic sampleDut(input int n, output logic [31:0] sw, output logic [31:0] sj,
                           output logic [31:0] sb, output logic [31:0] sv, output logic [31:0] sc,
                           output logic [31:0] scnt, output logic [31:0] sbp);
    if (n == 3) begin
      sw = 32'(w3); sj = 32'(j3); sb = 32'(busy3); sv = 32'(valid3);
      sc = 32'(minc3); scnt = 32'(mc3); sbp = 32'(bp3);
    end else begin
      sw = 32'(w4); sj = 32'(j4); sb = 32'(busy4); sv = 32'(valid4);
      sc = 32'(minc4); scnt = 32'(mc4); sbp = 32'(bp4);
    end
  endtask

  // Permutations appear in lexicographic order when tuples are counted with d[0] most significant
  task automatic model(input int n, input bit mx);
    int d [4];
    int v, s, used;
    bit ok, found;
    qw.delete();
    qj.delete();
    found    = 1'b0;
    exp_cost = 0;
    exp_cnt  = 0;
    exp_perm = '0;
    for (int code = 0; code < n ** n; code++) begin
      v = code;
      for (int k = n - 1; k >= 0; k--) begin
        d[k] = v % n;
        v    = v / n;
      end
      used = 0;
      ok   = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (((used >> d[k]) & 1) != 0) ok = 1'b0;
        used = used | (1 << d[k]);
      end
      if (!ok) continue;
      s = 0;
      for (int k = 0; k < n; k++) begin
        s += (n == 3) ? int'(tab3[k][d[k]]) : int'(tab4[k][d[k]]);
        qw.push_back(k);
        qj.push_back(d[k]);
      end
      qw.push_back(0); qj.push_back(0);
      qw.push_back(0); qj.push_back(0);
      if (!found || (mx ? (s > exp_cost) : (s < exp_cost))) begin
        found    = 1'b1;
        exp_cost = s;
        exp_cnt  = 1;
        for (int k = 0; k < n; k++) exp_perm[k*2 +: 2] = 2'(d[k]);
      end else if (s == exp_cost) begin
        exp_cnt++;
      end
    end
  endtask

  task automatic doAbort(input int n);
    logic [31:0] sw, sj, sb, sv, sc, scnt, sbp;
    RST = 1'b1;
    setStart(n, 1'b0, 1'b0);
    #1;
    sampleDut(n, sw, sj, sb, sv, sc, scnt, sbp);
    checkOutput("abort_busy", sb, 32'd0);
    checkOutput("abort_valid", sv, 32'd0);
    checkOutput("abort_mincost", sc, 32'd0);
    checkOutput("abort_count", scnt, 32'd0);
    checkOutput("abort_perm", sbp, 32'd0);
    prev_cost[3] = 0;
    prev_cost[4] = 0;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      sampleDut(n, sw, sj, sb, sv, sc, scnt, sbp);
      checkOutput("post_abort_valid", sv, 32'd0);
      checkOutput("post_abort_busy", sb, 32'd0);
    end
  endtask

  // One job on instance n; every cycle after acceptance is compared with the
  // reference sweep, and Valid must be high in cycle N!*(N+2) only.
  task automatic applyStimulus(input int n, input bit mx, input bit poke,
                               input int abort_at, input bit chain);
    logic [31:0] sw, sj, sb, sv, sc, scnt, sbp;
    int len;
    model(n, mx);
    len = qw.size();
    if (!chain) @(negedge CLK);
    setStart(n, 1'b1, mx);
    @(posedge CLK);
    #1;
    setStart(n, 1'b0, ~mx);
    for (int c = 1; c <= len; c++) begin
      @(negedge CLK);
      if (c == abort_at) begin
        doAbort(n);
        return;
      end
      sampleDut(n, sw, sj, sb, sv, sc, scnt, sbp);
      checkOutput("busy", sb, 32'd1);
      checkOutput("valid", sv, 32'(c == len));
      checkOutput("W", sw, 32'(qw[c-1]));
      checkOutput("J", sj, 32'(qj[c-1]));
      if (c == len - 1) checkOutput("hold_mincost", sc, 32'(prev_cost[n]));
      if (c == len) begin
        checkOutput("mincost", sc, 32'(exp_cost));
        checkOutput("matchcount", scnt, 32'(exp_cnt));
        checkOutput("bestperm", sbp, 32'(exp_perm));
        prev_cost[n] = exp_cost;
      end
      if (poke && ((c % 7) == 3 || c == len)) setStart(n, 1'b1, ~mx);
      else setStart(n, 1'b0, ~mx);
    end
    @(negedge CLK);
    sampleDut(n, sw, sj, sb, sv, sc, scnt, sbp);
    checkOutput("idle_busy", sb, 32'd0);
    checkOutput("idle_valid", sv, 32'd0);
    checkOutput("idle_mincost", sc, 32'(exp_cost));
    if (poke) setStart(n, 1'b1, ~mx);
    else setStart(n, 1'b0, 1'b0);
  endtask

  task automatic fillRandom4();
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++)
        tab4[w][j] = 7'($urandom_range(0, 127));
  endtask

  initial begin
    logic [31:0] sw, sj, sb, sv, sc, scnt, sbp;
    RST = 1'b1;
    start3 = 1'b0; mode3 = 1'b0; start4 = 1'b0; mode4 = 1'b0;
    prev_cost[3] = 0;
    prev_cost[4] = 0;
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++) begin
        tab3[w][j] = '0;
        tab4[w][j] = '0;
      end

    @(posedge CLK);
    @(negedge CLK);
    for (int n = 3; n <= 4; n++) begin
      sampleDut(n, sw, sj, sb, sv, sc, scnt, sbp);
      checkOutput("reset_W", sw, 32'd0);
      checkOutput("reset_J", sj, 32'd0);
      checkOutput("reset_busy", sb, 32'd0);
      checkOutput("reset_valid", sv, 32'd0);
      checkOutput("reset_mincost", sc, 32'd0);
      checkOutput("reset_count", scnt, 32'd0);
      checkOutput("reset_perm", sbp, 32'd0);
    end
    RST = 1'b0;
    $display("[TB] reset released");

    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        tab3[w][j] = 7'(w * 3 + j + 1);
    applyStimulus(3, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("n3_equal_cost", 32'(minc3), 32'd15);
    checkOutput("n3_equal_count", 32'(mc3), 32'd6);
    checkOutput("n3_equal_perm", 32'(bp3), 32'h24);

    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        tab3[w][j] = '0;
    tab3[0][0] = 7'd9;
    applyStimulus(3, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("n3_spike_min_cost", 32'(minc3), 32'd0);
    checkOutput("n3_spike_min_count", 32'(mc3), 32'd4);
    checkOutput("n3_spike_min_perm", 32'(bp3), 32'h21);
    applyStimulus(3, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("n3_spike_max_cost", 32'(minc3), 32'd9);
    checkOutput("n3_spike_max_count", 32'(mc3), 32'd2);
    checkOutput("n3_spike_max_perm", 32'(bp3), 32'h24);

    $display("[TB] N=4 random jobs with start pulses while busy");
    fillRandom4();
    applyStimulus(4, 1'b0, 1'b1, 0, 1'b0);
    fillRandom4();
    applyStimulus(4, 1'b1, 1'b0, 0, 1'b1);

    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++)
        tab4[w][j] = 7'd127;
    applyStimulus(4, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("n4_flat_cost", 32'(minc4), 32'd508);
    checkOutput("n4_flat_count", 32'(mc4), 32'd24);

    $display("[TB] N=4 reset during READ");
    fillRandom4();
    applyStimulus(4, 1'b0, 1'b0, 3, 1'b0);
    fillRandom4();
    applyStimulus(4, 1'b1, 1'b0, 0, 1'b0);
    fillRandom4();
    applyStimulus(4, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
